pipe_stage_reg: RTL and testbench

Parametrised, flow-controlled pipeline stage register for the processor pipeline. Replaces the fixed-field IF/ID, ID/IX, IX/MEM and MEM/WB latches: each stage boundary concatenates its fields into one WIDTH-bit bus. Adds a valid/ready handshake, an optional 2-entry skid buffer so a downstream stall does not lose an in-flight instruction, and independent stall-hold and flush-to-bubble controls. Sits between two pipeline stages. Upstream writes into the stage; downstream consumes from the stage.

---
 rtl/pipe_stage_reg_if.sv | 34 +++
 rtl/pipe_stage_reg.sv | 141 ++++++++++++++
 tb/tb_pipe_stage_reg.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/pipe_stage_reg_if.sv
`default_nettype none
// ============================================================================
// Module   : pipe_stage_reg_if
// Purpose  : Handshake bundle around one pipeline stage register.
//            Carries the upstream side (in_*) and the downstream side
//            (out_*) of the stage.
// Modports : slave  - the stage register itself
//            master - the environment around the stage (upstream producer
//                     plus downstream consumer)
// Ports    : in_valid/in_data/in_ready    upstream write handshake
//            out_valid/out_data/out_ready downstream read handshake
// Revision : 1.0 - initial release
// ============================================================================
interface pipe_stage_reg_if #(
  parameter int WIDTH = 32
) ();
  logic             in_valid;
  logic [WIDTH-1:0] in_data;
  logic             in_ready;
  logic             out_valid;
  logic [WIDTH-1:0] out_data;
  logic             out_ready;

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data
  );

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data
  );
endinterface
`default_nettype wire

// File: rtl/pipe_stage_reg.sv
`default_nettype none
// ============================================================================
// Module   : pipe_stage_reg
// Purpose  : Flow-controlled pipeline stage register with optional 2-entry
//            skid buffer, stall-hold and flush-to-bubble. State updates on
//            the falling edge of clk, like the other pipeline registers.
// Ports    : clk          stage clock (falling-edge active)
//            reset        synchronous active-high reset
//            bus          handshake bundle (slave side)
//            stall_i      hold: blocks pop regardless of out_ready
//            flush_i      discard all contents
//            stall_out_o  stall_i delayed by one edge
//            occupancy_o  number of entries held (0..2)
// Revision : 1.0 - initial release
// ============================================================================
module pipe_stage_reg #(
  parameter int WIDTH = 32,
  parameter bit SKID  = 1'b1
) (
  input  wire logic           clk,
  input  wire logic           reset,
  pipe_stage_reg_if.slave     bus,
  input  wire logic           stall_i,
  input  wire logic           flush_i,
  output logic                stall_out_o,
  output logic [1:0]          occupancy_o
);

  // State encoding equals occupancy so the count falls straight out.
  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_ONE   = 2'd1,
    S_FULL  = 2'd2
  } state_t;

  logic r_stall_q;

  always_ff @(negedge clk) begin
    if (reset) r_stall_q <= 1'b0;
    else       r_stall_q <= stall_i;
  end

  assign stall_out_o = r_stall_q;

  generate
    if (SKID) begin : g_skid
      state_t           r_state_q;
      logic [WIDTH-1:0] r_main_q;
      logic [WIDTH-1:0] r_skid_q;
      logic             r_in_ready_q;
      logic             w_push;
      logic             w_pop;

      assign w_push = bus.in_valid && r_in_ready_q;
      assign w_pop  = (r_state_q != S_EMPTY) && bus.out_ready && !stall_i;

      // in_ready is tracked as its own register so upstream sees a clean
      // flop output that never depends on out_ready.
      always_ff @(negedge clk) begin
        if (reset || flush_i) begin
          r_state_q    <= S_EMPTY;
          r_main_q     <= '0;
          r_skid_q     <= '0;
          r_in_ready_q <= 1'b1;
        end else begin
          case (r_state_q)
            S_EMPTY: begin
              if (w_push) begin
                r_state_q <= S_ONE;
                r_main_q  <= bus.in_data;
              end
            end
            S_ONE: begin
              if (w_push && w_pop) begin
                r_main_q <= bus.in_data;
              end else if (w_push) begin
                r_state_q    <= S_FULL;
                r_skid_q     <= bus.in_data;
                r_in_ready_q <= 1'b0;
              end else if (w_pop) begin
                r_state_q <= S_EMPTY;
                r_main_q  <= '0;
              end
            end
            S_FULL: begin
              // in_ready is low here, so only a pop can happen.
              if (w_pop) begin
                r_state_q    <= S_ONE;
                r_main_q     <= r_skid_q;
                r_skid_q     <= '0;
                r_in_ready_q <= 1'b1;
              end
            end
            default: begin
              r_state_q    <= S_EMPTY;
              r_main_q     <= '0;
              r_skid_q     <= '0;
              r_in_ready_q <= 1'b1;
            end
          endcase
        end
      end

      assign bus.in_ready  = r_in_ready_q;
      assign bus.out_valid = (r_state_q != S_EMPTY);
      assign bus.out_data  = r_main_q;
      assign occupancy_o   = r_state_q;
    end else begin : g_noskid
      logic             r_valid_q;
      logic [WIDTH-1:0] r_data_q;
      logic             w_in_ready;
      logic             w_push;
      logic             w_pop;

      // Combinational ready: space exists if empty or the head leaves now.
      assign w_in_ready = !r_valid_q || (bus.out_ready && !stall_i);
      assign w_push     = bus.in_valid && w_in_ready;
      assign w_pop      = r_valid_q && bus.out_ready && !stall_i;

      always_ff @(negedge clk) begin
        if (reset || flush_i) begin
          r_valid_q <= 1'b0;
          r_data_q  <= '0;
        end else if (w_push) begin
          r_valid_q <= 1'b1;
          r_data_q  <= bus.in_data;
        end else if (w_pop) begin
          r_valid_q <= 1'b0;
          r_data_q  <= '0;
        end
      end

      assign bus.in_ready  = w_in_ready;
      assign bus.out_valid = r_valid_q;
      assign bus.out_data  = r_data_q;
      assign occupancy_o   = {1'b0, r_valid_q};
    end
  endgenerate

endmodule
`default_nettype wire

// File: tb/tb_pipe_stage_reg.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipe_stage_reg
// Purpose  : Directed self-checking bench for pipe_stage_reg. Four instances:
//            a = SKID=1/WIDTH=32, b = SKID=0/WIDTH=32, c = WIDTH=1,
//            d = WIDTH=200. clk/reset/stall/flush are shared; idle instances
//            keep in_valid low.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_pipe_stage_reg;

  logic       clk = 1'b0;
  logic       reset;
  logic       stall;
  logic       flush;
  logic       so_a, so_b, so_c, so_d;
  logic [1:0] occ_a, occ_b, occ_c, occ_d;
  int         checks   = 0;
  int         failures = 0;

  pipe_stage_reg_if #(.WIDTH(32))  ifa ();
  pipe_stage_reg_if #(.WIDTH(32))  ifb ();
  pipe_stage_reg_if #(.WIDTH(1))   ifc ();
  pipe_stage_reg_if #(.WIDTH(200)) ifd ();

  pipe_stage_reg #(.WIDTH(32), .SKID(1'b1)) u_a (
    .clk(clk), .reset(reset), .bus(ifa.slave), .stall_i(stall), .flush_i(flush),
    .stall_out_o(so_a), .occupancy_o(occ_a));
  pipe_stage_reg #(.WIDTH(32), .SKID(1'b0)) u_b (
    .clk(clk), .reset(reset), .bus(ifb.slave), .stall_i(stall), .flush_i(flush),
    .stall_out_o(so_b), .occupancy_o(occ_b));
  pipe_stage_reg #(.WIDTH(1), .SKID(1'b1)) u_c (
    .clk(clk), .reset(reset), .bus(ifc.slave), .stall_i(stall), .flush_i(flush),
    .stall_out_o(so_c), .occupancy_o(occ_c));
  pipe_stage_reg #(.WIDTH(200), .SKID(1'b1)) u_d (
    .clk(clk), .reset(reset), .bus(ifd.slave), .stall_i(stall), .flush_i(flush),
    .stall_out_o(so_d), .occupancy_o(occ_d));

  always #5 clk = ~clk;

  // Advance past one falling (active) edge, then settle on the rising edge.
  task automatic tick();
    @(negedge clk);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    ifa.in_valid = 1'b1; ifa.in_data = 32'hDEADBEEF;
    tick(); tick();
    checks++; if (ifa.out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b want=0", ifa.out_valid); end
    checks++; if (ifa.out_data !== 32'h0) begin failures++; $display("FAIL reset_out_data got=%h want=0", ifa.out_data); end
    checks++; if (occ_a !== 2'd0) begin failures++; $display("FAIL reset_occupancy got=%0d want=0", occ_a); end
    checks++; if (ifa.in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b want=1", ifa.in_ready); end
    checks++; if (so_a !== 1'b0) begin failures++; $display("FAIL reset_stall_out got=%b want=0", so_a); end
    checks++; if (ifb.in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready_skid0 got=%b want=1", ifb.in_ready); end
    ifa.in_valid = 1'b0;
    reset = 1'b0;
  endtask

  task automatic test_streaming();
    ifa.out_ready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      ifa.in_valid = 1'b1; ifa.in_data = i;
      tick();
      checks++; if (ifa.out_data !== i) begin failures++; $display("FAIL stream_data[%0d] got=%h want=%h", i, ifa.out_data, i); end
      checks++; if (ifa.out_valid !== 1'b1 || occ_a !== 2'd1 || ifa.in_ready !== 1'b1) begin
        failures++; $display("FAIL stream_flags[%0d] got v=%b occ=%0d rdy=%b want v=1 occ=1 rdy=1", i, ifa.out_valid, occ_a, ifa.in_ready);
      end
    end
    ifa.in_valid = 1'b0;
    tick();
    checks++; if (ifa.out_valid !== 1'b0 || ifa.out_data !== 32'h0) begin
      failures++; $display("FAIL stream_drain got v=%b d=%h want v=0 d=0", ifa.out_valid, ifa.out_data);
    end
    ifa.out_ready = 1'b0;
  endtask

  task automatic test_skid_absorb();
    ifa.in_valid = 1'b1; ifa.in_data = 32'hA;
    tick();
    checks++; if (occ_a !== 2'd1) begin failures++; $display("FAIL skid_one_occ got=%0d want=1", occ_a); end
    // stall wins over out_ready: B is absorbed into the skid entry
    stall = 1'b1; ifa.out_ready = 1'b1; ifa.in_data = 32'hB;
    tick();
    checks++; if (occ_a !== 2'd2 || ifa.in_ready !== 1'b0) begin
      failures++; $display("FAIL skid_full got occ=%0d rdy=%b want occ=2 rdy=0", occ_a, ifa.in_ready);
    end
    checks++; if (ifa.out_data !== 32'hA) begin failures++; $display("FAIL skid_head_held got=%h want=a", ifa.out_data); end
    checks++; if (so_a !== 1'b1) begin failures++; $display("FAIL stall_out_delayed got=%b want=1", so_a); end
    ifa.in_data = 32'hC;
    tick();
    checks++; if (occ_a !== 2'd2 || ifa.out_data !== 32'hA) begin
      failures++; $display("FAIL skid_reject_c got occ=%0d d=%h want occ=2 d=a", occ_a, ifa.out_data);
    end
    stall = 1'b0;
    tick();
    checks++; if (ifa.out_data !== 32'hB || occ_a !== 2'd1 || ifa.in_ready !== 1'b1) begin
      failures++; $display("FAIL skid_pop_a got d=%h occ=%0d rdy=%b want d=b occ=1 rdy=1", ifa.out_data, occ_a, ifa.in_ready);
    end
    checks++; if (so_a !== 1'b0) begin failures++; $display("FAIL stall_out_clear got=%b want=0", so_a); end
    tick();
    checks++; if (ifa.out_data !== 32'hC || occ_a !== 2'd1) begin
      failures++; $display("FAIL skid_accept_c got d=%h occ=%0d want d=c occ=1", ifa.out_data, occ_a);
    end
    ifa.in_valid = 1'b0;
    tick();
    checks++; if (occ_a !== 2'd0 || ifa.out_data !== 32'h0 || ifa.out_valid !== 1'b0) begin
      failures++; $display("FAIL skid_empty got occ=%0d d=%h v=%b want occ=0 d=0 v=0", occ_a, ifa.out_data, ifa.out_valid);
    end
    ifa.out_ready = 1'b0;
  endtask

  task automatic test_flush_priority();
    ifa.in_valid = 1'b1; ifa.in_data = 32'h11;
    tick();
    ifa.in_data = 32'h22;
    tick();
    checks++; if (occ_a !== 2'd2 || ifa.out_data !== 32'h11) begin
      failures++; $display("FAIL flush_setup got occ=%0d d=%h want occ=2 d=11", occ_a, ifa.out_data);
    end
    flush = 1'b1; ifa.in_data = 32'h33; ifa.out_ready = 1'b1;
    tick();
    checks++; if (ifa.out_valid !== 1'b0 || ifa.out_data !== 32'h0 || occ_a !== 2'd0 || ifa.in_ready !== 1'b1) begin
      failures++; $display("FAIL flush_full got v=%b d=%h occ=%0d rdy=%b want v=0 d=0 occ=0 rdy=1", ifa.out_valid, ifa.out_data, occ_a, ifa.in_ready);
    end
    // flush from EMPTY with in_ready=1: the push is acknowledged but dropped
    ifa.in_data = 32'h44;
    tick();
    checks++; if (ifa.out_valid !== 1'b0 || occ_a !== 2'd0) begin
      failures++; $display("FAIL flush_push_drop got v=%b occ=%0d want v=0 occ=0", ifa.out_valid, occ_a);
    end
    flush = 1'b0; ifa.in_valid = 1'b0;
    tick();
    checks++; if (ifa.out_valid !== 1'b0 || ifa.out_data !== 32'h0) begin
      failures++; $display("FAIL flush_no_ghost got v=%b d=%h want v=0 d=0", ifa.out_valid, ifa.out_data);
    end
    ifa.out_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    ifa.in_valid = 1'b1; ifa.in_data = 32'h66;
    tick();
    ifa.in_data = 32'h77;
    tick();
    stall = 1'b1;
    tick();
    reset = 1'b1;
    tick();
    checks++; if (occ_a !== 2'd0 || ifa.out_data !== 32'h0 || so_a !== 1'b0 || ifa.in_ready !== 1'b1) begin
      failures++; $display("FAIL reset_mid got occ=%0d d=%h so=%b rdy=%b want occ=0 d=0 so=0 rdy=1", occ_a, ifa.out_data, so_a, ifa.in_ready);
    end
    reset = 1'b0; stall = 1'b0; ifa.in_valid = 1'b0;
    tick();
  endtask

  task automatic test_skid0_pass();
    ifb.out_ready = 1'b0; ifb.in_valid = 1'b1; ifb.in_data = 32'h50;
    tick();
    checks++; if (ifb.out_valid !== 1'b1 || ifb.out_data !== 32'h50 || occ_b !== 2'd1) begin
      failures++; $display("FAIL skid0_hold got v=%b d=%h occ=%0d want v=1 d=50 occ=1", ifb.out_valid, ifb.out_data, occ_b);
    end
    ifb.in_data = 32'h55;
    #1;
    checks++; if (ifb.in_ready !== 1'b0) begin failures++; $display("FAIL skid0_blocked got=%b want=0", ifb.in_ready); end
    ifb.out_ready = 1'b1;
    #1;
    checks++; if (ifb.in_ready !== 1'b1) begin failures++; $display("FAIL skid0_comb_ready got=%b want=1", ifb.in_ready); end
    tick();
    checks++; if (ifb.out_data !== 32'h55 || ifb.out_valid !== 1'b1) begin
      failures++; $display("FAIL skid0_replace got d=%h v=%b want d=55 v=1", ifb.out_data, ifb.out_valid);
    end
    stall = 1'b1;
    #1;
    checks++; if (ifb.in_ready !== 1'b0) begin failures++; $display("FAIL skid0_stall_ready got=%b want=0", ifb.in_ready); end
    stall = 1'b0; ifb.in_valid = 1'b0;
    tick();
    checks++; if (ifb.out_valid !== 1'b0 || ifb.out_data !== 32'h0 || occ_b !== 2'd0) begin
      failures++; $display("FAIL skid0_bubble got v=%b d=%h occ=%0d want v=0 d=0 occ=0", ifb.out_valid, ifb.out_data, occ_b);
    end
    ifb.out_ready = 1'b0;
  endtask

  task automatic test_width_corners();
    logic [199:0] ones200;
    ones200 = '1;
    ifc.in_valid = 1'b1; ifc.in_data = 1'b1; ifc.out_ready = 1'b0;
    ifd.in_valid = 1'b1; ifd.in_data = ones200; ifd.out_ready = 1'b0;
    tick();
    checks++; if (ifc.out_data !== 1'b1 || ifc.out_valid !== 1'b1) begin
      failures++; $display("FAIL w1_ones got d=%b v=%b want d=1 v=1", ifc.out_data, ifc.out_valid);
    end
    checks++; if (ifd.out_data !== ones200 || ifd.out_valid !== 1'b1) begin
      failures++; $display("FAIL w200_ones got d=%h v=%b want all-ones v=1", ifd.out_data, ifd.out_valid);
    end
    ifc.in_valid = 1'b0; ifc.out_ready = 1'b1;
    ifd.in_valid = 1'b0; ifd.out_ready = 1'b1;
    tick();
    checks++; if (ifc.out_data !== 1'b0 || ifc.out_valid !== 1'b0) begin
      failures++; $display("FAIL w1_bubble got d=%b v=%b want d=0 v=0", ifc.out_data, ifc.out_valid);
    end
    checks++; if (ifd.out_data !== 200'h0 || ifd.out_valid !== 1'b0) begin
      failures++; $display("FAIL w200_bubble got d=%h v=%b want d=0 v=0", ifd.out_data, ifd.out_valid);
    end
    ifc.out_ready = 1'b0; ifd.out_ready = 1'b0;
  endtask

  initial begin
    reset = 1'b1; stall = 1'b0; flush = 1'b0;
    ifa.in_valid = 1'b0; ifa.in_data = '0; ifa.out_ready = 1'b0;
    ifb.in_valid = 1'b0; ifb.in_data = '0; ifb.out_ready = 1'b0;
    ifc.in_valid = 1'b0; ifc.in_data = '0; ifc.out_ready = 1'b0;
    ifd.in_valid = 1'b0; ifd.in_data = '0; ifd.out_ready = 1'b0;
    #1;
    test_reset();
    test_streaming();
    test_skid_absorb();
    test_flush_priority();
    test_reset_mid();
    test_skid0_pass();
    test_width_corners();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
